decode_stage: RTL

- Registered, parametrised RISC-V decode stage. Sits between fetch and execute.
- Takes one 32-bit instruction plus its PC per handshake and decodes it into a compact control word, sign-extended immediate and register indices.
- Holds results in a 2-entry skid buffer. Supports RV32/RV64, optional M extension and illegal-instruction detection.
- Replaces the flat combinational one-hot decoder in pipelined cores.

---
 rtl/decode_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RISC-V (RV32/RV64, optional M) decode stage with a
//            2-entry skid buffer and illegal-instruction detection.
// Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32,
    parameter int EN_M = 1,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_wen,
    output logic            out_rs1_ren,
    output logic            out_rs2_ren,
    output logic [3:0]      out_class,
    output logic [3:0]      out_funct,
    output logic            out_word,
    output logic            out_ebreak,
    output logic            out_ecall
);

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimmw = 7'b0011011;
    localparam logic [6:0] c_opc_opw    = 7'b0111011;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    localparam logic [3:0] c_cls_lui    = 4'd0;
    localparam logic [3:0] c_cls_auipc  = 4'd1;
    localparam logic [3:0] c_cls_jal    = 4'd2;
    localparam logic [3:0] c_cls_jalr   = 4'd3;
    localparam logic [3:0] c_cls_branch = 4'd4;
    localparam logic [3:0] c_cls_load   = 4'd5;
    localparam logic [3:0] c_cls_store  = 4'd6;
    localparam logic [3:0] c_cls_opimm  = 4'd7;
    localparam logic [3:0] c_cls_op     = 4'd8;
    localparam logic [3:0] c_cls_muldiv = 4'd9;
    localparam logic [3:0] c_cls_system = 4'd10;
    localparam logic [3:0] c_cls_ill    = 4'd15;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;
    localparam logic [6:0] c_f7_mul  = 7'b0000001;

    typedef enum logic [1:0] {
        c_st_empty = 2'd0,
        c_st_one   = 2'd1,
        c_st_full  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_wen;
        logic            rs1_ren;
        logic            rs2_ren;
        logic [3:0]      cls;
        logic [3:0]      funct;
        logic            word;
        logic            ebreak;
        logic            ecall;
    } entry_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [5:0]  w_f6;
    logic [3:0]  w_cls_raw;
    logic [3:0]  w_cls;
    logic        w_ill;
    logic        w_alt;
    logic        w_is_word;
    logic [31:0] w_imm32;
    logic [XLEN-1:0] w_imm;
    entry_t      w_dec;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_ld_main_in;
    logic        w_ld_main_skid;
    logic        w_ld_skid;
    entry_t      r_main;
    entry_t      r_skid;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];
    assign w_f6  = in_instr[31:26];

    // Class and legality; w_alt marks the sub/sra family whose instr[30] is kept.
    always_comb begin
        w_cls_raw = c_cls_ill;
        w_ill     = 1'b0;
        w_alt     = 1'b0;
        w_is_word = 1'b0;
        case (w_opc)
            c_opc_lui:    w_cls_raw = c_cls_lui;
            c_opc_auipc:  w_cls_raw = c_cls_auipc;
            c_opc_jal:    w_cls_raw = c_cls_jal;
            c_opc_jalr: begin
                w_cls_raw = c_cls_jalr;
                w_ill     = (w_f3 != 3'b000);
            end
            c_opc_branch: begin
                w_cls_raw = c_cls_branch;
                w_ill     = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_opc_load: begin
                w_cls_raw = c_cls_load;
                w_ill     = (w_f3 == 3'b111) ||
                            ((XLEN == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
            end
            c_opc_store: begin
                w_cls_raw = c_cls_store;
                w_ill     = w_f3[2] || ((XLEN == 32) && (w_f3 == 3'b011));
            end
            c_opc_opimm: begin
                w_cls_raw = c_cls_opimm;
                if (w_f3 == 3'b001) begin
                    w_ill = (XLEN == 32) ? (w_f7 != c_f7_base) : (w_f6 != 6'b000000);
                end else if (w_f3 == 3'b101) begin
                    w_alt = in_instr[30];
                    if (XLEN == 32) begin
                        w_ill = (w_f7 != c_f7_base) && (w_f7 != c_f7_alt);
                    end else begin
                        w_ill = (w_f6 != 6'b000000) && (w_f6 != 6'b010000);
                    end
                end
            end
            c_opc_op: begin
                if (w_f7 == c_f7_mul) begin
                    w_cls_raw = c_cls_muldiv;
                    w_ill     = (EN_M == 0);
                end else begin
                    w_cls_raw = c_cls_op;
                    if (w_f7 == c_f7_alt) begin
                        w_alt = 1'b1;
                        w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                    end else begin
                        w_ill = (w_f7 != c_f7_base);
                    end
                end
            end
            c_opc_opimmw: begin
                w_cls_raw = c_cls_opimm;
                w_is_word = 1'b1;
                case (w_f3)
                    3'b000:  w_ill = 1'b0;
                    3'b001:  w_ill = (w_f7 != c_f7_base);
                    3'b101: begin
                        w_alt = in_instr[30];
                        w_ill = (w_f7 != c_f7_base) && (w_f7 != c_f7_alt);
                    end
                    default: w_ill = 1'b1;
                endcase
                if (XLEN == 32) begin
                    w_ill = 1'b1;
                end
            end
            c_opc_opw: begin
                w_is_word = 1'b1;
                if (w_f7 == c_f7_mul) begin
                    w_cls_raw = c_cls_muldiv;
                    w_ill     = (EN_M == 0) || (w_f3 == 3'b001) ||
                                (w_f3 == 3'b010) || (w_f3 == 3'b011);
                end else begin
                    w_cls_raw = c_cls_op;
                    if (w_f7 == c_f7_base) begin
                        w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b001) && (w_f3 != 3'b101);
                    end else if (w_f7 == c_f7_alt) begin
                        w_alt = 1'b1;
                        w_ill = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                if (XLEN == 32) begin
                    w_ill = 1'b1;
                end
            end
            c_opc_system: begin
                w_cls_raw = c_cls_system;
                w_ill     = (in_instr != 32'h0000_0073) && (in_instr != 32'h0010_0073);
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_cls = w_ill ? c_cls_ill : w_cls_raw;

    always_comb begin
        w_imm32 = '0;
        case (w_cls)
            c_cls_lui, c_cls_auipc:
                w_imm32 = {in_instr[31:12], 12'b0};
            c_cls_jal:
                w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            c_cls_jalr, c_cls_load, c_cls_opimm:
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            c_cls_store:
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            c_cls_branch:
                w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    if (XLEN == 64) begin : g_imm_x64
        assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_imm_x32
        assign w_imm = w_imm32;
    end

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.instr   = in_instr;
        w_dec.imm     = w_imm;
        w_dec.rd      = in_instr[11:7];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.cls     = w_cls;
        w_dec.funct   = {w_alt & ~w_ill, w_f3};
        w_dec.word    = w_is_word & ~w_ill;
        w_dec.rd_wen  = (in_instr[11:7] != 5'd0) &&
                        ((w_cls <= c_cls_load) || (w_cls == c_cls_opimm) ||
                         (w_cls == c_cls_op) || (w_cls == c_cls_muldiv)) &&
                        (w_cls != c_cls_branch);
        w_dec.rs1_ren = (w_cls >= c_cls_jalr) && (w_cls <= c_cls_muldiv);
        w_dec.rs2_ren = (w_cls == c_cls_branch) || (w_cls == c_cls_store) ||
                        (w_cls == c_cls_op) || (w_cls == c_cls_muldiv);
        w_dec.ebreak  = (w_cls == c_cls_system) && in_instr[20];
        w_dec.ecall   = (w_cls == c_cls_system) && !in_instr[20];
    end

    // Skid control: main always holds the older entry, skid only fills from ONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (in_valid) begin
                        w_state_nxt  = c_st_one;
                        w_ld_main_in = 1'b1;
                    end
                end
                c_st_one: begin
                    if (in_valid && out_ready) begin
                        w_ld_main_in = 1'b1;
                    end else if (in_valid) begin
                        w_state_nxt = c_st_full;
                        w_ld_skid   = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt = c_st_empty;
                    end
                end
                c_st_full: begin
                    if (out_ready) begin
                        w_state_nxt    = c_st_one;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_st_empty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main <= w_dec;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready    = (r_state != c_st_full);
    assign out_valid   = (r_state != c_st_empty);
    assign out_pc      = r_main.pc;
    assign out_instr   = r_main.instr;
    assign out_imm     = r_main.imm;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd_wen  = r_main.rd_wen;
    assign out_rs1_ren = r_main.rs1_ren;
    assign out_rs2_ren = r_main.rs2_ren;
    assign out_class   = r_main.cls;
    assign out_funct   = r_main.funct;
    assign out_word    = r_main.word;
    assign out_ebreak  = r_main.ebreak;
    assign out_ecall   = r_main.ecall;

endmodule
`default_nettype wire
